// File: rtl/bsram_pkg.sv
// Shared types and constants for the cartridge BSRAM arbiter.
package bsram_pkg;

  localparam int         BSRAM_ADDR_W = 20;
  localparam logic [7:0] CPU_Q_RST    = 8'hFF;

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_RDWAIT = 2'd1,
    H_ACK    = 2'd2
  } host_state_t;

endpackage

// File: rtl/bsram_autosave_timer.sv
// Idle timer that raises an autosave request once a dirty image has sat
// untouched by CPU writes for AUTOSAVE_CYCLES clocks.
module bsram_autosave_timer #(
  parameter logic [31:0] AUTOSAVE_CYCLES = 32'd10_800_000
) (
  input  logic WCLK,
  input  logic RST,
  input  logic cpu_wr,
  input  logic dirty,
  input  logic dirty_clr,
  output logic save_req
);

  logic [31:0] idle_cnt;

  always_ff @(posedge WCLK) begin
    if (RST) begin
      idle_cnt <= '0;
      save_req <= 1'b0;
    end else begin
      // Saturate rather than wrap so a long-idle image keeps requesting.
      if (cpu_wr)
        idle_cnt <= '0;
      else if (dirty && (idle_cnt != 32'hFFFF_FFFF))
        idle_cnt <= idle_cnt + 32'd1;

      if (dirty_clr)
        save_req <= 1'b0;
      else if (dirty && !cpu_wr && (idle_cnt >= AUTOSAVE_CYCLES))
        save_req <= 1'b1;
    end
  end

endmodule

// File: rtl/bsram_arbiter.sv
// Single-port BSRAM arbiter: CPU accesses at fixed bus-cycle timing, host save/load
// accesses in idle slots, plus dirty tracking. Autosave timer under BSRAM_AUTOSAVE_EN.
module bsram_arbiter
  import bsram_pkg::*;
#(
  parameter int          ADDR_W          = BSRAM_ADDR_W,
  parameter logic [31:0] AUTOSAVE_CYCLES = 32'd10_800_000
) (
  input  logic              WCLK,
  input  logic              RST,
  input  logic              SYSCLKF_CE,
  input  logic              SYSCLKR_CE,
  input  logic              CPU_CE_N,
  input  logic              CPU_OE_N,
  input  logic              CPU_WE_N,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [7:0]        CPU_D,
  output logic [7:0]        CPU_Q,
  input  logic              HOST_REQ,
  input  logic              HOST_WE,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [7:0]        HOST_D,
  output logic              HOST_ACK,
  output logic [7:0]        HOST_Q,
  input  logic              DIRTY_CLR,
  output logic              DIRTY,
  output logic              SAVE_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_D,
  output logic              MEM_WE,
  output logic              MEM_RD,
  input  logic [7:0]        MEM_Q
);

  logic              cpu_rd_req, cpu_wr_req;
  logic              cpu_rd_pend, cpu_wr_pend;
  logic              rd_issue, wr_issue;
  logic              cpu_rd_p1;
  logic [ADDR_W-1:0] rd_addr_p0, wr_addr_p0;
  logic [7:0]        wr_d_p0;
  logic              host_grant;
  host_state_t       h_state, h_next;

  assign cpu_rd_req = SYSCLKF_CE & ~CPU_CE_N & ~CPU_OE_N;
  assign cpu_wr_req = SYSCLKR_CE & ~CPU_CE_N & ~CPU_WE_N;
  assign wr_issue   = cpu_wr_pend;
  assign rd_issue   = cpu_rd_pend & ~cpu_wr_pend;

  // Stage p0: qualify CPU strobes on the bus-cycle enables and latch operands
  always_ff @(posedge WCLK) begin
    if (RST) begin
      cpu_rd_pend <= 1'b0;
      cpu_wr_pend <= 1'b0;
    end else begin
      cpu_rd_pend <= cpu_rd_req | (cpu_rd_pend & ~rd_issue);
      cpu_wr_pend <= cpu_wr_req;
    end
  end

  always_ff @(posedge WCLK) begin
    if (cpu_rd_req)
      rd_addr_p0 <= CPU_ADDR;
    if (cpu_wr_req) begin
      wr_addr_p0 <= CPU_ADDR;
      wr_d_p0    <= CPU_D;
    end
  end

  // Issue stage: one memory operation per cycle, CPU write > CPU read > host
  always_comb begin
    MEM_WE   = 1'b0;
    MEM_RD   = 1'b0;
    MEM_ADDR = '0;
    MEM_D    = '0;
    if (wr_issue) begin
      MEM_WE   = 1'b1;
      MEM_ADDR = wr_addr_p0;
      MEM_D    = wr_d_p0;
    end else if (rd_issue) begin
      MEM_RD   = 1'b1;
      MEM_ADDR = rd_addr_p0;
    end else if (host_grant) begin
      MEM_WE   = HOST_WE;
      MEM_RD   = ~HOST_WE;
      MEM_ADDR = HOST_ADDR;
      MEM_D    = HOST_WE ? HOST_D : 8'h00;
    end
  end

  always_ff @(posedge WCLK) begin
    if (RST)
      h_state <= H_IDLE;
    else
      h_state <= h_next;
  end

  always_comb begin
    h_next = h_state;
    case (h_state)
      H_IDLE:   if (host_grant) h_next = HOST_WE ? H_ACK : H_RDWAIT;
      H_RDWAIT: h_next = H_ACK;
      H_ACK:    h_next = H_IDLE;
      default:  h_next = H_IDLE;
    endcase
  end

  // A CPU op that is being requested or issued this cycle keeps the host off the port.
  always_comb begin
    host_grant = (h_state == H_IDLE) & HOST_REQ & ~RST &
                 ~(cpu_rd_req | cpu_wr_req | cpu_rd_pend | cpu_wr_pend);
    HOST_ACK   = (h_state == H_ACK);
  end

  // Stage p1: registered read data returns, dirty tracking
  always_ff @(posedge WCLK) begin
    if (RST) begin
      cpu_rd_p1 <= 1'b0;
      CPU_Q     <= CPU_Q_RST;
      HOST_Q    <= 8'h00;
      DIRTY     <= 1'b0;
    end else begin
      cpu_rd_p1 <= rd_issue;
      if (cpu_rd_p1)
        CPU_Q <= MEM_Q;
      if (h_state == H_RDWAIT)
        HOST_Q <= MEM_Q;
      if (wr_issue)
        DIRTY <= 1'b1;
      else if (DIRTY_CLR)
        DIRTY <= 1'b0;
    end
  end

`ifdef BSRAM_AUTOSAVE_EN
  bsram_autosave_timer #(
    .AUTOSAVE_CYCLES (AUTOSAVE_CYCLES)
  ) u_autosave (
    .WCLK      (WCLK),
    .RST       (RST),
    .cpu_wr    (wr_issue),
    .dirty     (DIRTY),
    .dirty_clr (DIRTY_CLR),
    .save_req  (SAVE_REQ)
  );
`else
  assign SAVE_REQ = 1'b0 & (AUTOSAVE_CYCLES != 32'd0);
`endif

endmodule

// File: tb/tb_bsram_arbiter.sv
// Directed testbench for bsram_arbiter with a behavioural registered-read BSRAM.
module tb_bsram_arbiter;

  localparam int ADDR_W = 20;

  logic WCLK = 1'b0;
  always #5 WCLK = ~WCLK;

  logic              RST, SYSCLKF_CE, SYSCLKR_CE;
  logic              CPU_CE_N, CPU_OE_N, CPU_WE_N;
  logic [ADDR_W-1:0] CPU_ADDR, HOST_ADDR, MEM_ADDR;
  logic [7:0]        CPU_D, CPU_Q, HOST_D, HOST_Q, MEM_D, MEM_Q;
  logic              HOST_REQ, HOST_WE, HOST_ACK;
  logic              DIRTY_CLR, DIRTY, SAVE_REQ, MEM_WE, MEM_RD;

  logic [7:0] mem [0:4095];
  int n_total = 0;
  int n_bad   = 0;

  bsram_arbiter #(
    .ADDR_W          (ADDR_W),
    .AUTOSAVE_CYCLES (32'd100)
  ) dut (
    .WCLK       (WCLK),
    .RST        (RST),
    .SYSCLKF_CE (SYSCLKF_CE),
    .SYSCLKR_CE (SYSCLKR_CE),
    .CPU_CE_N   (CPU_CE_N),
    .CPU_OE_N   (CPU_OE_N),
    .CPU_WE_N   (CPU_WE_N),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_D      (CPU_D),
    .CPU_Q      (CPU_Q),
    .HOST_REQ   (HOST_REQ),
    .HOST_WE    (HOST_WE),
    .HOST_ADDR  (HOST_ADDR),
    .HOST_D     (HOST_D),
    .HOST_ACK   (HOST_ACK),
    .HOST_Q     (HOST_Q),
    .DIRTY_CLR  (DIRTY_CLR),
    .DIRTY      (DIRTY),
    .SAVE_REQ   (SAVE_REQ),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_D      (MEM_D),
    .MEM_WE     (MEM_WE),
    .MEM_RD     (MEM_RD),
    .MEM_Q      (MEM_Q)
  );

  always @(posedge WCLK) begin
    if (MEM_WE) mem[MEM_ADDR[11:0]] <= MEM_D;
    if (MEM_RD) MEM_Q <= mem[MEM_ADDR[11:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge WCLK);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cpu_q"},    CPU_Q,    32'hFF);
    chk({tag, "_host_q"},   HOST_Q,   32'h00);
    chk({tag, "_host_ack"}, HOST_ACK, 32'h0);
    chk({tag, "_dirty"},    DIRTY,    32'h0);
    chk({tag, "_save_req"}, SAVE_REQ, 32'h0);
    chk({tag, "_mem_we"},   MEM_WE,   32'h0);
    chk({tag, "_mem_rd"},   MEM_RD,   32'h0);
    chk({tag, "_mem_addr"}, MEM_ADDR, 32'h0);
    chk({tag, "_mem_d"},    MEM_D,    32'h0);
  endtask

  // Returns in the issue cycle, with the enable dropped but OE still low.
  task automatic cpu_read(input logic [ADDR_W-1:0] a);
    step();
    SYSCLKF_CE = 1'b1; CPU_CE_N = 1'b0; CPU_OE_N = 1'b0; CPU_ADDR = a;
    step();
    SYSCLKF_CE = 1'b0;
  endtask

  // Returns in the issue cycle with all write strobes released.
  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    step();
    SYSCLKR_CE = 1'b1; CPU_CE_N = 1'b0; CPU_WE_N = 1'b0; CPU_ADDR = a; CPU_D = d;
    step();
    SYSCLKR_CE = 1'b0; CPU_CE_N = 1'b1; CPU_WE_N = 1'b1;
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, input logic [7:0] exp, input string tag);
    step();
    HOST_REQ = 1'b1; HOST_WE = 1'b0; HOST_ADDR = a;
    @(negedge WCLK);
    chk({tag, "_grant"}, MEM_RD, 32'h1);
    chk({tag, "_addr"},  MEM_ADDR, 32'(a));
    step();
    @(negedge WCLK);
    chk({tag, "_ack_wait"}, HOST_ACK, 32'h0);
    step();
    HOST_REQ = 1'b0;
    @(negedge WCLK);
    chk({tag, "_ack"},  HOST_ACK, 32'h1);
    chk({tag, "_data"}, HOST_Q, 32'(exp));
    step();
    @(negedge WCLK);
    chk({tag, "_ack_drop"}, HOST_ACK, 32'h0);
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [7:0] d, input string tag);
    step();
    HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = a; HOST_D = d;
    @(negedge WCLK);
    chk({tag, "_grant"}, MEM_WE, 32'h1);
    chk({tag, "_addr"},  MEM_ADDR, 32'(a));
    chk({tag, "_data"},  MEM_D, 32'(d));
    step();
    HOST_REQ = 1'b0;
    @(negedge WCLK);
    chk({tag, "_ack"}, HOST_ACK, 32'h1);
    step();
    @(negedge WCLK);
    chk({tag, "_ack_drop"}, HOST_ACK, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h123] = 8'h5A;
    MEM_Q = 8'h00;
    RST = 1'b1; SYSCLKF_CE = 1'b0; SYSCLKR_CE = 1'b0;
    CPU_CE_N = 1'b1; CPU_OE_N = 1'b1; CPU_WE_N = 1'b1; CPU_ADDR = '0; CPU_D = 8'h00;
    HOST_REQ = 1'b0; HOST_WE = 1'b0; HOST_ADDR = '0; HOST_D = 8'h00; DIRTY_CLR = 1'b0;

    repeat (3) step();
    @(negedge WCLK);
    check_reset("rst");
    step();
    RST = 1'b0;

    // CPU read of preloaded byte; strobe held past the enable must not re-read
    cpu_read(20'h00123);
    @(negedge WCLK);
    chk("rd_issue", MEM_RD, 32'h1);
    chk("rd_addr",  MEM_ADDR, 32'h00123);
    step();
    @(negedge WCLK);
    chk("rd_cpuq_early", CPU_Q, 32'hFF);
    chk("rd_once",       MEM_RD, 32'h0);
    step();
    CPU_CE_N = 1'b1; CPU_OE_N = 1'b1;
    @(negedge WCLK);
    chk("rd_cpuq",  CPU_Q, 32'h5A);
    chk("rd_dirty", DIRTY, 32'h0);

    // CPU write, then host reads it back
    cpu_write(20'h00010, 8'hC3);
    @(negedge WCLK);
    chk("wr_issue",  MEM_WE, 32'h1);
    chk("wr_addr",   MEM_ADDR, 32'h00010);
    chk("wr_data",   MEM_D, 32'hC3);
    chk("wr_dirty0", DIRTY, 32'h0);
    step();
    @(negedge WCLK);
    chk("wr_dirty1", DIRTY, 32'h1);
    chk("wr_once",   MEM_WE, 32'h0);
    host_read(20'h00010, 8'hC3, "hrd_c3");

    // Host write requested while a CPU read is issuing: grant slips one cycle
    cpu_read(20'h00010);
    HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 20'h00020; HOST_D = 8'h77;
    @(negedge WCLK);
    chk("ct_cpu_first", MEM_RD, 32'h1);
    chk("ct_cpu_addr",  MEM_ADDR, 32'h00010);
    chk("ct_host_held", MEM_WE, 32'h0);
    step();
    CPU_CE_N = 1'b1; CPU_OE_N = 1'b1;
    @(negedge WCLK);
    chk("ct_host_grant", MEM_WE, 32'h1);
    chk("ct_one_op",     MEM_RD, 32'h0);
    chk("ct_host_addr",  MEM_ADDR, 32'h00020);
    chk("ct_host_data",  MEM_D, 32'h77);
    chk("ct_ack_wait",   HOST_ACK, 32'h0);
    step();
    HOST_REQ = 1'b0;
    @(negedge WCLK);
    chk("ct_ack",  HOST_ACK, 32'h1);
    chk("ct_cpuq", CPU_Q, 32'hC3);
    step();
    @(negedge WCLK);
    chk("ct_ack_drop", HOST_ACK, 32'h0);
    host_read(20'h00020, 8'h77, "hrd_77");

    // Dirty clear alone, then clear coinciding with a CPU write issue
    step();
    DIRTY_CLR = 1'b1;
    step();
    DIRTY_CLR = 1'b0;
    @(negedge WCLK);
    chk("dirty_clr", DIRTY, 32'h0);
    cpu_write(20'h00030, 8'h11);
    DIRTY_CLR = 1'b1;
    @(negedge WCLK);
    chk("sw_issue", MEM_WE, 32'h1);
    step();
    DIRTY_CLR = 1'b0;
    @(negedge WCLK);
    chk("dirty_set_wins", DIRTY, 32'h1);

    // Reset while a host read is in its wait state
    step();
    HOST_REQ = 1'b1; HOST_WE = 1'b0; HOST_ADDR = 20'h00123;
    @(negedge WCLK);
    chk("rr_grant", MEM_RD, 32'h1);
    step();
    RST = 1'b1;
    @(negedge WCLK);
    chk("rr_no_ack_wait", HOST_ACK, 32'h0);
    step();
    @(negedge WCLK);
    check_reset("rr");
    step();
    RST = 1'b0;
    @(negedge WCLK);
    chk("rr_regrant", MEM_RD, 32'h1);
    chk("rr_addr",    MEM_ADDR, 32'h00123);
    chk("rr_no_ack",  HOST_ACK, 32'h0);
    step();
    @(negedge WCLK);
    chk("rr_ack_wait", HOST_ACK, 32'h0);
    step();
    HOST_REQ = 1'b0;
    @(negedge WCLK);
    chk("rr_ack",  HOST_ACK, 32'h1);
    chk("rr_data", HOST_Q, 32'h5A);

    // Host writes leave the image clean
    host_write(20'h00040, 8'h99, "hwr");
    chk("hwr_clean", DIRTY, 32'h0);
    host_read(20'h00040, 8'h99, "hrd_99");

`ifdef BSRAM_AUTOSAVE_EN
    cpu_write(20'h00050, 8'h01);
    repeat (48) step();
    cpu_write(20'h00051, 8'h02);
    repeat (59) step();
    @(negedge WCLK);
    chk("as_restart", SAVE_REQ, 32'h0);
    repeat (35) step();
    @(negedge WCLK);
    chk("as_early", SAVE_REQ, 32'h0);
    repeat (11) step();
    @(negedge WCLK);
    chk("as_rise", SAVE_REQ, 32'h1);
    step();
    DIRTY_CLR = 1'b1;
    step();
    DIRTY_CLR = 1'b0;
    @(negedge WCLK);
    chk("as_clr", SAVE_REQ, 32'h0);
    chk("as_dirty_clr", DIRTY, 32'h0);
`else
    cpu_write(20'h00050, 8'h01);
    repeat (120) step();
    @(negedge WCLK);
    chk("as_off", SAVE_REQ, 32'h0);
    chk("as_off_dirty", DIRTY, 32'h1);
`endif

    step();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
